// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 in-place FFT sequencer -- butterfly read/write addresses and twiddle index.
// Optional macro FFT_ADDR_GEN_BITREV_EN: bit-reverse stage-0 read addresses for natural-order input.
module fft_addr_gen #(
  parameter int LOG2N      = 10,
  parameter int BF_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic             bf_valid,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam int JW     = LOG2N - 1;
  localparam int STAGES = BF_LATENCY + 1;
  localparam int DW     = $clog2(BF_LATENCY + 2);

  localparam logic [JW-1:0]    J_LAST = '1;
  localparam logic [DW-1:0]    D_LAST = DW'(BF_LATENCY + 1);
  localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE_A  = LOG2N'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q;
  logic [DW-1:0]   dcnt_q;
  logic [3:0]      stage_q;
  logic            issue;

  // index 0 is the issue cycle; bf_valid taps 1, write-back taps STAGES
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][LOG2N-1:0] wa_pipe;
  logic [STAGES:0][LOG2N-1:0] wb_pipe;

  logic [JW-1:0]    kmask, k, tw_d;
  logic [3:0]       tw_sh;
  logic [LOG2N-1:0] addr_a, addr_b, rd_a_d, rd_b_d;

`ifdef FFT_ADDR_GEN_BITREV_EN
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (!hold) begin
                 issue = 1'b1;
                 if (j_q == J_LAST) state_d = S_DRAIN;
               end
      S_DRAIN: if (!hold && dcnt_q == D_LAST)
                 state_d = (stage_q == S_LAST) ? S_FIN : S_RUN;
      S_FIN:   if (!hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // j splits into group g (upper bits) and offset k (low s bits); A inserts a 0 at bit s
  always_comb begin
    kmask  = JW'((32'd1 << stage_q) - 32'd1);
    k      = j_q & kmask;
    addr_a = {j_q & ~kmask, 1'b0} | {1'b0, k};
    addr_b = addr_a | (ONE_A << stage_q);
    tw_sh  = 4'(JW) - stage_q;
    tw_d   = k << tw_sh;
`ifdef FFT_ADDR_GEN_BITREV_EN
    rd_a_d = (stage_q == 4'd0) ? bitrev(addr_a) : addr_a;
    rd_b_d = (stage_q == 4'd0) ? bitrev(addr_b) : addr_b;
`else
    rd_a_d = addr_a;
    rd_b_d = addr_b;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      j_q          <= '0;
      dcnt_q       <= '0;
      stage_q      <= '0;
      vld_pipe     <= '0;
      wa_pipe      <= '0;
      wb_pipe      <= '0;
      done         <= 1'b0;
      twiddle_addr <= '0;
      rd_addr_a    <= '0;
      rd_addr_b    <= '0;
    end else begin
      state_q <= state_d;
      // start is accepted in IDLE even under hold
      if (state_q == S_IDLE && start) begin
        stage_q <= '0;
        j_q     <= '0;
        dcnt_q  <= '0;
      end
      if (!hold) begin
        vld_pipe <= {vld_pipe[STAGES-1:0], issue};
        wa_pipe  <= {wa_pipe[STAGES-1:0], issue ? addr_a : wa_pipe[0]};
        wb_pipe  <= {wb_pipe[STAGES-1:0], issue ? addr_b : wb_pipe[0]};
        done     <= (state_q == S_FIN);
        if (issue) begin
          j_q          <= j_q + 1'b1;
          twiddle_addr <= tw_d;
          rd_addr_a    <= rd_a_d;
          rd_addr_b    <= rd_b_d;
        end
        if (state_q == S_DRAIN) begin
          dcnt_q <= (dcnt_q == D_LAST) ? '0 : dcnt_q + 1'b1;
          if (dcnt_q == D_LAST && stage_q != S_LAST) stage_q <= stage_q + 1'b1;
        end
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stage     = stage_q;
  assign bf_valid  = vld_pipe[1];
  assign wr_en     = vld_pipe[STAGES];
  assign wr_addr_a = wa_pipe[STAGES];
  assign wr_addr_b = wb_pipe[STAGES];

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: scoreboard bench -- expected butterflies queued at start, monitor pops on bf_valid/wr_en.
module tb_fft_addr_gen;
  localparam int LOG2N   = 10;
  localparam int BFL     = 4;
  localparam int NH      = 1 << (LOG2N - 1);
  localparam int RUN_LAT = LOG2N * NH + LOG2N * (BFL + 2) + 1;

  logic             clk = 1'b0;
  logic             rst, start, hold;
  logic             busy, done, bf_valid, wr_en;
  logic [3:0]       stage;
  logic [LOG2N-2:0] twiddle_addr;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

  fft_addr_gen #(.LOG2N(LOG2N), .BF_LATENCY(BFL)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .stage(stage), .twiddle_addr(twiddle_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .bf_valid(bf_valid),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int j; int a; int b; int ra; int rb; int tw; } bf_t;
  bf_t rdq[$];
  bf_t wrq[$];

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, start_cyc = 0, exp_lat = 0, done_cnt = 0, wr_cnt = 0;
  logic held_edge = 1'b0, seen_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (x[i]) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // reference: every butterfly of every stage, in issue order
  task automatic push_run();
    bf_t e;
    for (int s = 0; s < LOG2N; s++)
      for (int j = 0; j < NH; j++) begin
        int half = 1 << s;
        e.s  = s;
        e.j  = j;
        e.a  = (j / half) * 2 * half + (j % half);
        e.b  = e.a + half;
        e.tw = ((j % half) << (LOG2N - 1 - s)) % NH;
        e.ra = e.a;
        e.rb = e.b;
`ifdef FFT_ADDR_GEN_BITREV_EN
        if (s == 0) begin e.ra = brev(e.a); e.rb = brev(e.b); end
`endif
        rdq.push_back(e);
        wrq.push_back(e);
      end
  endtask

  function automatic logic [56:0] snap();
    return {stage, twiddle_addr, rd_addr_a, rd_addr_b, bf_valid, wr_en,
            wr_addr_a, wr_addr_b, done, busy};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    held_edge = hold;
  end

  // monitor: outputs after a held edge must be frozen; otherwise pop on bf_valid / wr_en
  initial begin
    logic [56:0] p_snap;
    int p_ra, p_rb, p_tw, p_st;
    logic p_done;
    bf_t e;
    p_snap = '0; p_ra = 0; p_rb = 0; p_tw = 0; p_st = 0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (held_edge) chk("hold_freeze", snap(), p_snap);
        else begin
          if (bf_valid) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
              e = rdq.pop_front();
              chk("rd_a", p_ra, e.ra);
              chk("rd_b", p_rb, e.rb);
              chk("twiddle", p_tw, e.tw);
              chk("stage", p_st, e.s);
              if (e.j == 0 && e.s > 0) chk("stage_order", wr_cnt >= e.s * NH, 1);
`ifdef FFT_ADDR_GEN_BITREV_EN
              if (e.s == 0 && e.j == 1) begin chk("k027_a", p_ra, 256); chk("k027_b", p_rb, 768); end
`else
              if (e.s == 0 && e.j == 1) begin chk("k027_a", p_ra, 2); chk("k027_b", p_rb, 3); end
`endif
              if (e.s == 3 && e.j == 13) begin
                chk("k028_a", p_ra, 21); chk("k028_b", p_rb, 29); chk("k028_tw", p_tw, 320);
              end
              if (e.s == 9 && e.j == 5) begin
                chk("k028b_a", p_ra, 5); chk("k028b_b", p_rb, 517); chk("k028b_tw", p_tw, 5);
              end
            end
          end
          if (wr_en) begin
            if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
              e = wrq.pop_front();
              chk("wr_a", wr_addr_a, e.a);
              chk("wr_b", wr_addr_b, e.b);
              wr_cnt++;
            end
          end
          if (done) begin
            chk("done_lat", cyc - start_cyc, exp_lat);
            chk("done_pulse", p_done, 0);
            chk("busy_at_done", busy, 0);
            chk("wr_total", wr_cnt, LOG2N * NH);
            chk("queues_empty", rdq.size() + wrq.size(), 0);
            done_cnt++;
            seen_done = 1'b1;
          end
        end
      end
      p_snap = snap();
      p_ra = rd_addr_a; p_rb = rd_addr_b; p_tw = twiddle_addr; p_st = stage; p_done = done;
    end
  end

  // mode 0: plain, 1: random hold, 2: 7-cycle hold burst, 3: start pokes while busy
  task automatic run_fft(input int mode);
    int holds = 0;
    push_run();
    wr_cnt = 0;
    seen_done = 1'b0;
    exp_lat = RUN_LAT;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    start_cyc = cyc;
    for (int t = 1; t < RUN_LAT + 1000 && !seen_done; t++) begin
      hold = 1'b0;
      start = 1'b0;
      if (mode == 1 && t > 100 && t < 4000 && $urandom_range(7) == 0) hold = 1'b1;
      if (mode == 2 && t >= 2000 && t < 2007) hold = 1'b1;
      if (mode == 3 && t < 5000 && $urandom_range(63) == 0) start = 1'b1;
      if (hold) holds++;
      exp_lat = RUN_LAT + holds;
      if (t == 10) chk("busy_running", busy, 1);
      @(posedge clk); #2;
    end
    hold = 1'b0;
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("idle_after", busy, 0);
  endtask

  task automatic reset_mid_run();
    push_run();
    wr_cnt = 0;
    seen_done = 1'b0;
    exp_lat = RUN_LAT;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    start_cyc = cyc;
    repeat (1000) @(posedge clk);
    #2;
    chk("busy_pre_rst", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    rdq.delete();
    wrq.delete();
    #1;
    chk("rst_outputs", snap(), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      chk("post_rst_wr", wr_en, 0);
      chk("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", snap(), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    run_fft(0);
    run_fft(1);
    run_fft(2);
    run_fft(3);
    reset_mid_run();
    run_fft(0);
    chk("done_count", done_cnt, 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
